// File: rtl/math_log2_pipe_if.sv
// Ready/valid bundle for math_log2_pipe: sample in, log2 result out.
// master drives samples and out_ready; slave is the log2 unit.
interface math_log2_pipe_if #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 10,
  parameter int TAG_WIDTH  = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN_WIDTH-1:0]  din;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  out_zero;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, din, in_tag, out_ready,
    input  in_ready, out_valid, dout, out_zero, out_tag
  );

  modport slave (
    input  in_valid, din, in_tag, out_ready,
    output in_ready, out_valid, dout, out_zero, out_tag
  );
endinterface

// File: rtl/math_log2_pipe.sv
// Pipelined fixed-point log2 with global stall; MATH_LOG2_INTERP_EN adds a
// linear-interpolation stage between adjacent fraction table entries.
module math_log2_pipe #(
  parameter int DIN_WIDTH       = 32,
  parameter int DIN_DECI_WIDTH  = 0,
  parameter int DOUT_WIDTH      = 10,
  parameter int DOUT_DECI_WIDTH = 4,
  parameter int LUT_ADDR_WIDTH  = 5,
  parameter int TAG_WIDTH       = 1
) (
  input logic clk,
  input logic rst,
  math_log2_pipe_if.slave io
);

  localparam int F          = DOUT_DECI_WIDTH;
  localparam int M          = LUT_ADDR_WIDTH;
  localparam int IW         = DOUT_WIDTH - F;
  localparam int PW         = $clog2(DIN_WIDTH);
  localparam int R          = 4;
  localparam int GUARD_BITS = 8;
  localparam int LUT_W      = F + 1;
  localparam int LUT_BITS   = ((1 << M) + 1) * LUT_W;
  localparam logic [DOUT_WIDTH-1:0] MOST_NEG = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  if (IW < PW + 1) begin : g_chk_iw
    $error("math_log2_pipe: DOUT_WIDTH-DOUT_DECI_WIDTH cannot hold the integer part");
  end
  if (M > DIN_WIDTH - 1) begin : g_chk_m
    $error("math_log2_pipe: LUT_ADDR_WIDTH must be at most DIN_WIDTH-1");
  end

  // log2(1 + idx/2^M) by repeated squaring in Q2.30; truncating to
  // F+GUARD_BITS bits and then rounding half-up gives the exact rounding.
  function automatic logic [LUT_W-1:0] lut_entry(input int idx);
    logic [63:0] x;
    logic [63:0] acc;
    logic [63:0] rnd;
    if (idx >= (1 << M)) return LUT_W'(1 << F);
    x   = (((64'd1 << M) + 64'(idx)) << 30) >> M;
    acc = 64'd0;
    for (int k = 0; k < F + GUARD_BITS; k++) begin
      x   = (x * x) >> 30;
      acc = acc << 1;
      if (x >= (64'd2 << 30)) begin
        acc = acc | 64'd1;
        x   = x >> 1;
      end
    end
    rnd = (acc + (64'd1 << (GUARD_BITS - 1))) >> GUARD_BITS;
    if (rnd > 64'((1 << F) - 1)) rnd = 64'((1 << F) - 1);
    return LUT_W'(rnd);
  endfunction

  function automatic logic [LUT_BITS-1:0] build_lut();
    logic [LUT_BITS-1:0] t;
    t = '0;
    for (int i = 0; i <= (1 << M); i++) t[i*LUT_W +: LUT_W] = lut_entry(i);
    return t;
  endfunction

  localparam logic [LUT_BITS-1:0] LUT_TBL = build_lut();

  function automatic logic [LUT_W-1:0] lut_rd(input logic [M:0] a);
    return LUT_TBL[a*LUT_W +: LUT_W];
  endfunction

  function automatic logic [PW-1:0] msb_idx(input logic [DIN_WIDTH-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIN_WIDTH; i++) if (v[i]) idx = PW'(i);
    return idx;
  endfunction

  function automatic logic signed [IW-1:0] int_part(input logic [PW-1:0] p);
    return IW'($signed({1'b0, p})) - IW'(DIN_DECI_WIDTH);
  endfunction

  function automatic logic [DOUT_WIDTH-1:0] assemble(input logic zero,
                                                     input logic signed [IW-1:0] ip,
                                                     input logic [F-1:0] fr);
    if (zero) return MOST_NEG;
    return {ip, fr};
  endfunction

`ifdef MATH_LOG2_INTERP_EN
  // Table is monotonic, so hi >= lo; the sum can only reach 2^F, which saturates.
  function automatic logic [F-1:0] interp_frac(input logic [LUT_W-1:0] lo,
                                               input logic [LUT_W-1:0] hi,
                                               input logic [R-1:0] r);
    logic [LUT_W+R-1:0] prod;
    logic [LUT_W:0]     sum;
    prod = (LUT_W+R)'(hi - lo) * (LUT_W+R)'(r);
    sum  = (LUT_W+1)'(lo) + (LUT_W+1)'(prod >> R);
    if (sum > (LUT_W+1)'((1 << F) - 1)) sum = (LUT_W+1)'((1 << F) - 1);
    return F'(sum);
  endfunction
`endif

  logic adv;
  logic out_valid_r;
  logic [DOUT_WIDTH-1:0] dout_r;
  logic out_zero_r;
  logic [TAG_WIDTH-1:0] out_tag_r;

  assign adv         = !(out_valid_r && !io.out_ready);
  assign io.in_ready = adv;
  assign io.out_valid = out_valid_r;
  assign io.dout      = dout_r;
  assign io.out_zero  = out_zero_r;
  assign io.out_tag   = out_tag_r;

  // S1: input register
  logic                 vld_p0;
  logic [DIN_WIDTH-1:0] din_p0;
  logic [TAG_WIDTH-1:0] tag_p0;

  // S2: leading-one position and zero detect
  logic                 vld_p1;
  logic [DIN_WIDTH-1:0] din_p1;
  logic [TAG_WIDTH-1:0] tag_p1;
  logic [PW-1:0]        p_p1;
  logic                 zero_p1;

  // S3: normalised mantissa address and integer part
  logic                  vld_p2;
  logic [TAG_WIDTH-1:0]  tag_p2;
  logic [M-1:0]          addr_p2;
  logic signed [IW-1:0]  int_p2;
  logic                  zero_p2;
  logic [PW-1:0]         sh_p1;
  logic [DIN_WIDTH-1:0]  norm_p1;

  assign sh_p1   = PW'(DIN_WIDTH - 1) - p_p1;
  assign norm_p1 = din_p1 << sh_p1;

`ifdef MATH_LOG2_INTERP_EN
  logic [R-1:0]           rem_p2;
  logic [DIN_WIDTH+R-1:0] ext_p1;
  assign ext_p1 = {norm_p1, {R{1'b0}}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= io.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      din_p0  <= io.din;
      tag_p0  <= io.in_tag;
      // ---- S1 -> S2
      din_p1  <= din_p0;
      tag_p1  <= tag_p0;
      p_p1    <= msb_idx(din_p0);
      zero_p1 <= (din_p0 == '0);
      // ---- S2 -> S3
      tag_p2  <= tag_p1;
      int_p2  <= int_part(p_p1);
      zero_p2 <= zero_p1;
`ifdef MATH_LOG2_INTERP_EN
      addr_p2 <= M'(ext_p1 >> (DIN_WIDTH - 1 - M + R));
      rem_p2  <= R'(ext_p1 >> (DIN_WIDTH - 1 - M));
`else
      addr_p2 <= M'(norm_p1 >> (DIN_WIDTH - 1 - M));
`endif
    end
  end

`ifdef MATH_LOG2_INTERP_EN
  // S4a: fetch both table neighbours
  logic                 vld_p3;
  logic [TAG_WIDTH-1:0] tag_p3;
  logic [LUT_W-1:0]     lo_p3;
  logic [LUT_W-1:0]     hi_p3;
  logic [R-1:0]         rem_p3;
  logic signed [IW-1:0] int_p3;
  logic                 zero_p3;

  always_ff @(posedge clk) begin
    if (rst)      vld_p3 <= 1'b0;
    else if (adv) vld_p3 <= vld_p2;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      tag_p3  <= tag_p2;
      lo_p3   <= lut_rd({1'b0, addr_p2});
      hi_p3   <= lut_rd({1'b0, addr_p2} + 1'b1);
      rem_p3  <= rem_p2;
      int_p3  <= int_p2;
      zero_p3 <= zero_p2;
    end
  end

  // S4b: interpolate and register the result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      dout_r      <= '0;
      out_zero_r  <= 1'b0;
      out_tag_r   <= '0;
    end else if (adv) begin
      out_valid_r <= vld_p3;
      dout_r      <= assemble(zero_p3, int_p3, interp_frac(lo_p3, hi_p3, rem_p3));
      out_zero_r  <= zero_p3;
      out_tag_r   <= tag_p3;
    end
  end
`else
  // S4: table lookup and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      dout_r      <= '0;
      out_zero_r  <= 1'b0;
      out_tag_r   <= '0;
    end else if (adv) begin
      out_valid_r <= vld_p2;
      dout_r      <= assemble(zero_p2, int_p2, F'(lut_rd({1'b0, addr_p2})));
      out_zero_r  <= zero_p2;
      out_tag_r   <= tag_p2;
    end
  end
`endif

endmodule

// File: tb/tb_math_log2_pipe.sv
// Randomised and directed bench for math_log2_pipe against a real-valued
// log2 reference; honours MATH_LOG2_INTERP_EN for latency and fraction model.
module tb_math_log2_pipe;
  localparam int DW = 32;
  localparam int OW = 10;
  localparam int F  = 4;
  localparam int M  = 5;
  localparam int R  = 4;
  localparam int TW = 1;
`ifdef MATH_LOG2_INTERP_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  bit   clk;
  logic rst;
  always #5 clk = ~clk;

  math_log2_pipe_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .TAG_WIDTH(TW)) ifa ();
  math_log2_pipe_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW), .TAG_WIDTH(TW)) ifb ();

  math_log2_pipe #(.DIN_WIDTH(DW), .DIN_DECI_WIDTH(0), .DOUT_WIDTH(OW),
                   .DOUT_DECI_WIDTH(F), .LUT_ADDR_WIDTH(M), .TAG_WIDTH(TW))
    dut_a (.clk(clk), .rst(rst), .io(ifa));

  math_log2_pipe #(.DIN_WIDTH(DW), .DIN_DECI_WIDTH(8), .DOUT_WIDTH(OW),
                   .DOUT_DECI_WIDTH(F), .LUT_ADDR_WIDTH(M), .TAG_WIDTH(TW))
    dut_b (.clk(clk), .rst(rst), .io(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Reference fraction table straight from the real-valued definition.
  int lut_ref [0:(1<<M)];
  initial begin
    for (int a = 0; a < (1 << M); a++) begin
      real v;
      v = (2.0 ** F) * $ln(1.0 + real'(a) / (2.0 ** M)) / $ln(2.0);
      lut_ref[a] = $rtoi(v + 0.5);
      if (lut_ref[a] > (1 << F) - 1) lut_ref[a] = (1 << F) - 1;
    end
    lut_ref[1 << M] = 1 << F;
  end

  function automatic logic [OW-1:0] ref_log2(input logic [31:0] d, input int deci);
    longint unsigned mant;
    int p, a, frac, val;
    if (d == 0) return OW'(1 << (OW - 1));
    p = 0;
    for (int i = 0; i < 32; i++) if (d[i]) p = i;
    mant = longint'(d) - (64'd1 << p);
    a    = int'((mant << M) >> p);
    frac = lut_ref[a];
`ifdef MATH_LOG2_INTERP_EN
    begin
      int r;
      r    = int'(((mant << (M + R)) >> p) % (1 << R));
      frac = lut_ref[a] + ((lut_ref[a+1] - lut_ref[a]) * r) / (1 << R);
      if (frac > (1 << F) - 1) frac = (1 << F) - 1;
    end
`endif
    val = (p - deci) * (1 << F) + frac;
    return OW'(val);
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        t;
    int          cyc;
  } sb_t;

  sb_t         q[$];
  sb_t         mon_e;
  int          cyc = 0;
  bit          lat_chk = 0;
  bit          mono_chk = 0;
  logic [OW-1:0] mono_prev;

  // Scoreboard: inputs enqueue on transfer, outputs must come back in order.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      check_eq("in_ready_vs_stall", ifa.in_ready, !(ifa.out_valid && !ifa.out_ready));
      if (ifa.out_valid && ifa.out_ready) begin
        check_eq("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check_eq("dout", ifa.dout, ref_log2(mon_e.d, 0));
          check_eq("out_zero", ifa.out_zero, mon_e.d == 0);
          check_eq("out_tag", ifa.out_tag, mon_e.t);
          if (lat_chk) check_eq("latency", cyc - mon_e.cyc, LAT);
          if (mono_chk) begin
            check_eq("monotonic", ifa.dout >= mono_prev, 1);
            mono_prev = ifa.dout;
          end
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        mon_e.d   = ifa.din;
        mon_e.t   = ifa.in_tag;
        mon_e.cyc = cyc;
        q.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic t);
    bit ok;
    ok = 0;
    ifa.in_valid = 1'b1;
    ifa.din      = d;
    ifa.in_tag   = t;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = ifa.in_ready;
      @(posedge clk);
      #1;
    end
    check_eq("send_accept", ok, 1);
    ifa.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    check_eq("drain_empty", q.size(), 0);
  endtask

  task automatic dir_b(input logic [31:0] d, input logic [OW-1:0] exp);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b1;
    ifb.din      = d;
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 20 && !ifb.out_valid);
    check_eq("b_dout", ifb.dout, exp);
    check_eq("b_zero", ifb.out_zero, 0);
    check_eq("b_latency", n, LAT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.din = '0; ifa.in_tag = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.din = '0; ifb.in_tag = '0; ifb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_eq("rst_out_valid", ifa.out_valid, 0);
    check_eq("rst_dout", ifa.dout, 0);
    check_eq("rst_out_zero", ifa.out_zero, 0);
    check_eq("rst_out_tag", ifa.out_tag, 0);
    check_eq("rst_in_ready", ifa.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed values, including zero input and the sample after it.
    lat_chk = 1;
    send(32'd1, 1'b0);
    send(32'd3, 1'b1);
    send(32'h8000_0000, 1'b0);
    send(32'd0, 1'b1);
    send(32'd2, 1'b0);
    send(32'h0000_0061, 1'b1);
    send(32'hFFFF_FFFF, 1'b0);
    drain();

    // Monotonic sweep across one octave.
    mono_prev = '0;
    mono_chk  = 1;
    for (int v = 64; v < 128; v++) send(32'(v), 1'(v));
    drain();
    mono_chk = 0;

    // Random stream with a three-cycle backpressure burst.
    lat_chk = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          d = $urandom >> $urandom_range(0, 31);
          if (d == 0) d = 32'd1;
          send(d, 1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (40) @(posedge clk);
        #1 ifa.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ifa.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three samples in flight.
    lat_chk = 1;
    send(32'd5, 1'b1);
    send(32'd6, 1'b0);
    send(32'd7, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_out_valid", ifa.out_valid, 0);
    repeat (8) @(posedge clk);
    #1;
    send(32'd100, 1'b1);
    drain();

    // Fractional input format on the second instance.
    dir_b(32'h0000_0040, 10'h3E0);
    dir_b(32'h0000_0180, 10'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
